// File: rtl/dice_roller_if.sv
// -----------------------------------------------------------------------------
// dice_roller_if
//   Pin bundle of the dice roller core, mirroring the TinyTapeout user pins.
//   Ports:
//     ena      design selected (unused by the core)
//     ui_in    button inputs, [0]d4 .. [6]d100, [7] unused
//     uio_in   strap inputs: [5] button pol, [6] segment pol, [7] common pol
//     uo_out   segments a..g on [6:0], dp on [7]
//     uio_out  [0] units common, [1] tens common
//     uio_oe   output enables for uio_out
//   master drives the inputs (wrapper / bench), slave is the core.
// -----------------------------------------------------------------------------
interface dice_roller_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/dice_roller.sv
// -----------------------------------------------------------------------------
// dice_roller
//   Electronic dice core. Holding one of seven buttons tumbles a counter over
//   the range of that die (d4/d6/d8/d10/d12/d20/d100); releasing latches the
//   roll, which is shown on a two-digit multiplexed 7-segment display.
//   Ports:
//     clk      single clock
//     rst      synchronous active-high reset
//     bus      dice_roller_if.slave pin bundle (buttons, straps, segments,
//              digit commons, output enables)
//   Parameters:
//     MUX_BITS digit select toggles every 2**MUX_BITS clk cycles
// -----------------------------------------------------------------------------
module dice_roller #(
    parameter int MUX_BITS = 10
) (
    input  logic          clk,
    input  logic          rst,
    dice_roller_if.slave  bus
);

    // Die size of the lowest-index pressed button; 0 when nothing is pressed.
    function automatic logic [6:0] die_range(input logic [6:0] p);
        logic [6:0] n;
        n = 7'd0;
        if      (p[0]) n = 7'd4;
        else if (p[1]) n = 7'd6;
        else if (p[2]) n = 7'd8;
        else if (p[3]) n = 7'd10;
        else if (p[4]) n = 7'd12;
        else if (p[5]) n = 7'd20;
        else if (p[6]) n = 7'd100;
        return n;
    endfunction

    // Lit segment pattern, bit order g..a.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] units_digit(input logic [6:0] v);
        logic [6:0] r;
        r = v % 7'd10;
        return r[3:0];
    endfunction

    // 100 is shown as "00", so its tens digit folds back to 0.
    function automatic logic [3:0] tens_digit(input logic [6:0] v);
        logic [6:0] q;
        q = (v >= 7'd100) ? 7'd0 : v / 7'd10;
        return q[3:0];
    endfunction

    logic [6:0]        w_pressed_raw;
    logic [6:0]        r_sync1;
    logic [6:0]        r_sync2;
    logic              w_any;
    logic              r_prev_any;
    logic [6:0]        w_n;
    logic [6:0]        r_roll;
    logic [6:0]        r_shown;
    logic              r_shown_vld;   // 0 means the display is BLANK
    logic [MUX_BITS:0] r_mux_cnt;
    logic              w_sel;
    logic              w_com;
    logic [6:0]        w_lit;
    logic              w_unused;

    assign w_pressed_raw = ~(bus.ui_in[6:0] ^ {7{bus.uio_in[5]}});
    assign w_any         = |r_sync2;
    assign w_n           = die_range(r_sync2);
    assign w_sel         = r_mux_cnt[MUX_BITS];
    assign w_com         = bus.uio_in[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 7'd0;
            r_sync2     <= 7'd0;
            r_prev_any  <= 1'b0;
            r_roll      <= 7'd0;
            r_shown     <= 7'd0;
            r_shown_vld <= 1'b0;
            r_mux_cnt   <= '0;
        end else begin
            r_sync1    <= w_pressed_raw;
            r_sync2    <= r_sync1;
            r_prev_any <= w_any;
            r_mux_cnt  <= r_mux_cnt + {{MUX_BITS{1'b0}}, 1'b1};
            // Also wraps when a switch to a smaller die leaves roll above N.
            if (w_any) begin
                r_roll <= (r_roll >= w_n || r_roll == 7'd0) ? 7'd1 : r_roll + 7'd1;
            end
            // Latch on release only; roll is frozen while nothing is pressed.
            if (r_prev_any && !w_any) begin
                r_shown     <= r_roll;
                r_shown_vld <= 1'b1;
            end
        end
    end

    always_comb begin
        w_lit = 7'b0000000;
        if (r_shown_vld && !w_any) begin
            if (w_sel) begin
                if (r_shown >= 7'd10) begin
                    w_lit = seg7(tens_digit(r_shown));
                end
            end else begin
                w_lit = seg7(units_digit(r_shown));
            end
        end
    end

    // Polarity straps are applied combinationally; dp stays unlit.
    assign bus.uo_out  = bus.uio_in[6] ? {1'b0, w_lit} : ~{1'b0, w_lit};
    assign bus.uio_out = {6'b000000, (w_sel ? {w_com, ~w_com} : {~w_com, w_com})};
    assign bus.uio_oe  = 8'b0000_0011;

    assign w_unused = &{1'b0, bus.ena, bus.ui_in[7], bus.uio_in[4:0]};

endmodule

// File: tb/tb_dice_roller.sv
module tb_dice_roller;
    localparam int MB  = 3;
    localparam int LIM = (2 ** (MB + 1)) + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dice_roller_if bus();

    dice_roller #(.MUX_BITS(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // ---------------- behavioural model ----------------
    logic [6:0] m_p1 = 7'd0;
    logic [6:0] m_p2 = 7'd0;
    bit         m_prev = 1'b0;
    int         m_roll = 0;
    int         m_shown = -1;     // -1 = blank
    int         m_cyc = 0;

    function automatic int die_n(input logic [6:0] p);
        int n;
        n = 0;
        for (int i = 6; i >= 0; i--) begin
            if (p[i]) begin
                case (i)
                    0: n = 4;
                    1: n = 6;
                    2: n = 8;
                    3: n = 10;
                    4: n = 12;
                    5: n = 20;
                    default: n = 100;
                endcase
            end
        end
        return n;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'h3F; 1: s = 7'h06; 2: s = 7'h5B; 3: s = 7'h4F; 4: s = 7'h66;
            5: s = 7'h6D; 6: s = 7'h7D; 7: s = 7'h07; 8: s = 7'h7F; 9: s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] exp_lit(input int shown, input bit blank, input bit sel);
        if (blank || shown < 0) return 7'h00;
        if (!sel) return seg_of(shown % 10);
        if (shown < 10) return 7'h00;
        if (shown == 100) return seg_of(0);
        return seg_of(shown / 10);
    endfunction

    function automatic logic [7:0] btn(input logic [6:0] mask);
        return bus.uio_in[5] ? {1'b0, mask} : {1'b1, ~mask};
    endfunction

    always @(posedge clk) begin
        logic [6:0] p;
        bit any;
        int n;
        p = ~(bus.ui_in[6:0] ^ {7{bus.uio_in[5]}});
        if (rst) begin
            m_p1 = 7'd0; m_p2 = 7'd0; m_prev = 1'b0;
            m_roll = 0; m_shown = -1; m_cyc = 0;
        end else begin
            any = (m_p2 != 7'd0);
            if (m_prev && !any) m_shown = m_roll;
            if (any) begin
                n = die_n(m_p2);
                if (m_roll >= n || m_roll == 0) m_roll = 1;
                else m_roll = m_roll + 1;
            end
            m_prev = any;
            m_p2 = m_p1;
            m_p1 = p;
            m_cyc = m_cyc + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        logic [7:0] e_uo;
        logic [7:0] e_uio;
        logic [6:0] lit;
        bit sel;
        bit c;
        #1;
        if (chk_en) begin
            sel   = m_cyc[MB];
            c     = bus.uio_in[7];
            lit   = exp_lit(m_shown, (m_p2 != 7'd0), sel);
            e_uo  = bus.uio_in[6] ? {1'b0, lit} : ~{1'b0, lit};
            e_uio = {6'b0, (sel ? {c, ~c} : {~c, c})};
            checks++;
            if (bus.uo_out !== e_uo) begin
                failures++;
                $display("FAIL model_seg t=%0t got=%h exp=%h", $time, bus.uo_out, e_uo);
            end
            checks++;
            if (bus.uio_out !== e_uio) begin
                failures++;
                $display("FAIL model_com t=%0t got=%h exp=%h", $time, bus.uio_out, e_uio);
            end
            checks++;
            if (bus.uio_oe !== 8'h03) begin
                failures++;
                $display("FAIL uio_oe t=%0t got=%h exp=03", $time, bus.uio_oe);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] uio);
        @(negedge clk);
        bus.uio_in = uio;
        bus.ui_in  = btn(7'h00);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic hold(input logic [6:0] mask, input int n);
        @(negedge clk);
        bus.ui_in = btn(mask);
        tick(n);
        bus.ui_in = btn(7'h00);
    endtask

    // eu/et: hand-computed lit patterns (dp..a) for units and tens digits.
    task automatic check_disp(input string name, input logic [7:0] eu, input logic [7:0] et);
        logic [7:0] e;
        bit found;
        tick(4);
        for (int d = 0; d < 2; d++) begin
            found = 1'b0;
            for (int k = 0; k < LIM; k++) begin
                if (bus.uio_out[d] == bus.uio_in[7]) begin
                    found = 1'b1;
                    break;
                end
                tick(1);
            end
            e = (d == 0) ? eu : et;
            e = bus.uio_in[6] ? e : ~e;
            checks++;
            if (!found) begin
                failures++;
                $display("FAIL %s digit%0d timeout waiting for common, exp=%h", name, d, e);
            end else if (bus.uo_out !== e) begin
                failures++;
                $display("FAIL %s digit%0d got=%h exp=%h", name, d, bus.uo_out, e);
            end
        end
    endtask

    initial begin
        logic [1:0] cc;
        bus.ena    = 1'b1;
        bus.uio_in = 8'hA0;          // segment polarity low during reset check
        bus.ui_in  = 8'h00;
        rst = 1'b1;
        tick(2);
        checks++;
        if (bus.uo_out !== 8'hFF || bus.uio_out !== 8'h01) begin
            failures++;
            $display("FAIL reset_lowpol got=%h/%h exp=ff/01", bus.uo_out, bus.uio_out);
        end
        bus.uio_in = 8'hE0;
        bus.ui_in  = 8'h00;
        tick(1);
        checks++;
        if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h01 || bus.uio_oe !== 8'h03) begin
            failures++;
            $display("FAIL reset_state got=%h/%h/%h exp=00/01/03", bus.uo_out, bus.uio_out, bus.uio_oe);
        end
        chk_en = 1'b1;
        rst = 1'b0;
        check_disp("idle_blank", 8'h00, 8'h00);

        do_reset(8'hE0);
        hold(7'h02, 8);
        check_disp("d6x8", 8'h5B, 8'h00);
        tick(20);
        check_disp("d6x8_stable", 8'h5B, 8'h00);

        do_reset(8'hC0);
        hold(7'h40, 100);
        check_disp("d100x100", 8'h3F, 8'h3F);

        do_reset(8'hC0);
        hold(7'h40, 57);
        check_disp("d100x57", 8'h07, 8'h6D);

        do_reset(8'hE0);
        hold(7'h08, 10);
        check_disp("d10x10", 8'h3F, 8'h06);

        do_reset(8'hE0);
        hold(7'h01, 5);
        check_disp("d4x5", 8'h06, 8'h00);

        do_reset(8'hE0);
        hold(7'h02, 5);
        for (int c = 0; c < 4; c++) begin
            cc = c[1:0];
            @(negedge clk);
            bus.uio_in = {cc, 6'b100000};
            check_disp("pol_sweep", 8'h6D, 8'h00);
        end

        do_reset(8'hE0);
        hold(7'h21, 6);
        check_disp("d4_d20", 8'h5B, 8'h00);

        do_reset(8'hE0);
        @(negedge clk);
        bus.ui_in = btn(7'h20);
        tick(15);
        bus.ui_in = btn(7'h10);
        tick(3);
        bus.ui_in = btn(7'h00);
        check_disp("switch_d20_d12", 8'h4F, 8'h00);

        do_reset(8'hE0);
        @(negedge clk);
        bus.ui_in = btn(7'h02);
        tick(4);
        check_disp("held_blank", 8'h00, 8'h00);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        bus.ui_in = btn(7'h00);
        check_disp("rst_mid_press", 8'h4F, 8'h00);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
